// File: rtl/hbullet_sprite.sv
// Hive bullet sprite: waits a pseudo-random delay, then drops one bullet from the firing hive.
// The bullet is drawn against the scan position and can hit the bee, which costs one life.
module hbullet_sprite #(
  parameter int unsigned HBHeight  = 7,
  parameter int unsigned HBSpeed   = 2,
  parameter int unsigned BeeY      = 429,
  parameter int unsigned BeeWidth  = 34,
  parameter int unsigned BeeHeight = 27,
  parameter int unsigned HitFrames = 16,
  parameter int unsigned MinDelay  = 30,
  parameter int unsigned BottomY   = 470
) (
  input  logic       clk_pix,
  input  logic       rst_n,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  input  logic       de,
  input  logic       fire_en,
  input  logic [9:0] HiveX,
  input  logic [9:0] HiveY,
  input  logic [9:0] BeeX,
  output logic       HBulletSpriteOn,
  output logic [2:0] HBaddress,
  output logic [9:0] xHBullet,
  output logic [9:0] yHBullet,
  output logic [1:0] HBulletstate,
  output logic       HBhitBee,
  output logic [1:0] Lives,
  output logic       GameOver
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVING  = 2'd1,
    WAITING = 2'd2,
    HIT     = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  lfsr;
  logic [7:0]  delay_cnt;
  logic [7:0]  hit_cnt;

  logic        frame_tick;
  logic        lfsr_fb;
  logic [7:0]  delay_reload;
  logic [10:0] hive_x_off;
  logic [9:0]  fire_x;
  logic [10:0] bee_x_end;
  logic [10:0] y_bot;
  logic        hit_bee;
  logic        at_bottom;
  logic        draw_on;
  logic [2:0]  row_off;

  assign HBulletstate = state;
  assign GameOver     = (Lives == 2'd0);
  assign frame_tick   = (sx == 10'd639) && (sy == 10'd479);

  assign lfsr_fb      = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign delay_reload = 8'(MinDelay) + {2'b00, lfsr[5:0]};

  // Hive offset is widened so hives near the right edge clamp instead of wrapping.
  assign hive_x_off = {1'b0, HiveX} + 11'd16;
  assign fire_x     = (hive_x_off > 11'd639) ? 10'd639 : hive_x_off[9:0];

  assign bee_x_end = {1'b0, BeeX} + 11'(BeeWidth - 1);
  assign y_bot     = {1'b0, yHBullet} + 11'(HBHeight - 1);
  assign hit_bee   = ({1'b0, xHBullet} >= {1'b0, BeeX}) &&
                     ({1'b0, xHBullet} <= bee_x_end) &&
                     (y_bot >= 11'(BeeY)) &&
                     ({1'b0, yHBullet} <= 11'(BeeY + BeeHeight - 1));
  assign at_bottom = (yHBullet >= 10'(BottomY));

  assign draw_on = de && (state == MOVING) && (sx == xHBullet) &&
                   (sy >= yHBullet) && ({1'b0, sy} <= y_bot);
  assign row_off = sy[2:0] - yHBullet[2:0];

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      lfsr            <= 8'hA5;
      delay_cnt       <= '0;
      hit_cnt         <= '0;
      xHBullet        <= '0;
      yHBullet        <= '0;
      HBulletSpriteOn <= 1'b0;
      HBaddress       <= '0;
      HBhitBee        <= 1'b0;
      Lives           <= 2'd3;
    end else begin
      HBhitBee        <= 1'b0;
      HBulletSpriteOn <= draw_on;
      if (draw_on) begin
        HBaddress <= row_off;
      end

      if (frame_tick) begin
        lfsr <= {lfsr[6:0], lfsr_fb};
        unique case (state)
          IDLE: begin
            state     <= WAITING;
            delay_cnt <= delay_reload;
          end
          WAITING: begin
            // An expired delay stays at zero until firing is allowed again.
            if (delay_cnt == '0) begin
              if (fire_en && !GameOver) begin
                xHBullet <= fire_x;
                yHBullet <= HiveY;
                state    <= MOVING;
              end
            end else begin
              delay_cnt <= delay_cnt - 8'd1;
            end
          end
          MOVING: begin
            if (hit_bee) begin
              HBhitBee <= 1'b1;
              if (Lives != 2'd0) begin
                Lives <= Lives - 2'd1;
              end
              state    <= HIT;
              hit_cnt  <= 8'(HitFrames);
              xHBullet <= '0;
            end else if (at_bottom) begin
              state     <= WAITING;
              xHBullet  <= '0;
              delay_cnt <= delay_reload;
            end else begin
              yHBullet <= yHBullet + 10'(HBSpeed);
            end
          end
          HIT: begin
            // Leaving on the count 1->0 step keeps HIT visible for exactly HitFrames ticks.
            if (hit_cnt <= 8'd1) begin
              state     <= WAITING;
              hit_cnt   <= '0;
              delay_cnt <= delay_reload;
            end else begin
              hit_cnt <= hit_cnt - 8'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hbullet_sprite.sv
// Self-checking bench for hbullet_sprite: frame ticks are driven directly through sx/sy,
// and every tick is compared against a behavioural game model.
module tb_hbullet_sprite;

  logic       clk_pix = 1'b0;
  logic       rst_n   = 1'b0;
  logic [9:0] sx      = '0;
  logic [9:0] sy      = '0;
  logic       de      = 1'b0;
  logic       fire_en = 1'b0;
  logic [9:0] HiveX   = '0;
  logic [9:0] HiveY   = '0;
  logic [9:0] BeeX    = '0;
  logic       HBulletSpriteOn;
  logic [2:0] HBaddress;
  logic [9:0] xHBullet;
  logic [9:0] yHBullet;
  logic [1:0] HBulletstate;
  logic       HBhitBee;
  logic [1:0] Lives;
  logic       GameOver;

  hbullet_sprite dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .sx(sx), .sy(sy), .de(de),
    .fire_en(fire_en), .HiveX(HiveX), .HiveY(HiveY), .BeeX(BeeX),
    .HBulletSpriteOn(HBulletSpriteOn), .HBaddress(HBaddress),
    .xHBullet(xHBullet), .yHBullet(yHBullet), .HBulletstate(HBulletstate),
    .HBhitBee(HBhitBee), .Lives(Lives), .GameOver(GameOver)
  );

  always #20 clk_pix = ~clk_pix;

  int checks = 0;
  int errors = 0;

  // Game model: 0 idle, 1 falling, 2 waiting, 3 bee hit
  int m_state, m_x, m_y, m_lives, m_lfsr, m_delay, m_hitcnt, m_hit, m_on, m_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int next_lfsr(input int v);
    int fb;
    fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
    return ((v * 2) % 256) + fb;
  endfunction

  task automatic model_reset();
    m_state = 0; m_x = 0; m_y = 0; m_lives = 3; m_lfsr = 165;
    m_delay = 0; m_hitcnt = 0; m_hit = 0; m_on = 0; m_addr = 0;
  endtask

  task automatic model_tick();
    int reload, hx, bx;
    reload = 30 + (m_lfsr % 64);
    hx = int'(HiveX);
    bx = int'(BeeX);
    m_hit = 0;
    case (m_state)
      0: begin m_state = 2; m_delay = reload; end
      2: begin
        if (m_delay > 0) m_delay--;
        else if (fire_en && m_lives > 0) begin
          m_x = (hx + 16 > 639) ? 639 : hx + 16;
          m_y = int'(HiveY);
          m_state = 1;
        end
      end
      1: begin
        if (m_x >= bx && m_x <= bx + 33 && m_y + 6 >= 429 && m_y <= 455) begin
          m_hit = 1;
          if (m_lives > 0) m_lives--;
          m_state = 3; m_hitcnt = 16; m_x = 0;
        end else if (m_y >= 470) begin
          m_state = 2; m_x = 0; m_delay = reload;
        end else begin
          m_y = (m_y + 2) % 1024;
        end
      end
      default: begin
        if (m_hitcnt > 1) m_hitcnt--;
        else begin m_hitcnt = 0; m_state = 2; m_delay = reload; end
      end
    endcase
    m_lfsr = next_lfsr(m_lfsr);
  endtask

  task automatic check_core();
    chk("state", HBulletstate, m_state);
    chk("x", xHBullet, m_x);
    chk("y", yHBullet, m_y);
    chk("lives", Lives, m_lives);
    chk("gameover", GameOver, (m_lives == 0) ? 1 : 0);
    chk("hit_pulse", HBhitBee, m_hit);
  endtask

  // One frame tick cycle followed by one ordinary cycle; the hit pulse must be gone by then.
  task automatic tick();
    sx = 10'd639; sy = 10'd479; de = 1'b0;
    @(posedge clk_pix); #1;
    model_tick();
    check_core();
    sx = '0; sy = '0;
    @(posedge clk_pix); #1;
    chk("hit_pulse_end", HBhitBee, 0);
  endtask

  task automatic run_until(input int target, input int max_ticks, input string tag);
    int n;
    n = 0;
    while (m_state != target && n < max_ticks) begin
      tick();
      n++;
    end
    chk(tag, HBulletstate, target);
  endtask

  task automatic draw_step(input int sxv, input int syv, input logic dev);
    sx = 10'(sxv); sy = 10'(syv); de = dev;
    m_on = (dev && m_state == 1 && sxv == m_x && syv >= m_y && syv <= m_y + 6) ? 1 : 0;
    if (m_on != 0) m_addr = (syv - m_y) % 8;
    @(posedge clk_pix); #1;
    chk("sprite_on", HBulletSpriteOn, m_on);
    chk("sprite_addr", HBaddress, m_addr);
  endtask

  task automatic aim_at_bee();
    int fx;
    HiveX = 10'($urandom_range(0, 639));
    HiveY = 10'($urandom_range(150, 440));
    fx = (int'(HiveX) + 16 > 639) ? 639 : int'(HiveX) + 16;
    BeeX = 10'((fx >= 33) ? fx - int'($urandom_range(0, 33)) : 0);
  endtask

  initial begin
    int n;
    int r;
    model_reset();
    repeat (3) @(posedge clk_pix);
    #1;
    check_core();
    chk("reset_on", HBulletSpriteOn, 0);
    chk("reset_addr", HBaddress, 0);
    rst_n = 1'b1;
    @(posedge clk_pix); #1;

    // Miss: bullet falls past a bee far to the right and retires at the bottom
    fire_en = 1'b1; HiveX = 10'd100; HiveY = 10'd200; BeeX = 10'd500;
    tick();
    chk("first_tick_waiting", HBulletstate, 2);
    run_until(1, 150, "first_fire");
    chk("fire_x", xHBullet, 116);
    chk("fire_y", yHBullet, 200);
    run_until(2, 200, "bottom_retire");
    chk("bottom_x", xHBullet, 0);

    // Right-edge clamp and column scan of the drawn bullet
    HiveX = 10'd630;
    run_until(1, 150, "clamp_fire");
    chk("clamp_x", xHBullet, 639);
    repeat (5) tick();
    for (int k = -1; k <= 7; k++) draw_step(639, m_y + k, 1'b1);
    draw_step(638, m_y + 2, 1'b1);
    draw_step(639, m_y + 3, 1'b0);
    draw_step(0, 0, 1'b0);

    // Reset while the bullet is in flight
    repeat (3) tick();
    chk("pre_reset_moving", HBulletstate, 1);
    #5 rst_n = 1'b0;
    #1;
    model_reset();
    check_core();
    chk("async_on", HBulletSpriteOn, 0);
    chk("async_addr", HBaddress, 0);
    @(posedge clk_pix); #1;
    chk("reset_no_pulse", HBhitBee, 0);
    rst_n = 1'b1;

    // Directed hit on the bee
    HiveX = 10'd100; HiveY = 10'd200; BeeX = 10'd100;
    run_until(1, 150, "hit_fire");
    run_until(3, 200, "hit_enter");
    chk("hit_lives", Lives, 2);
    n = 0;
    repeat (20) begin
      tick();
      if (HBulletstate == 2'd3) n++;
    end
    chk("hit_frames", n + 1, 16);
    chk("after_hit_state", HBulletstate, 2);

    // Randomized rounds while a spare life remains
    r = 0;
    while (m_lives > 1 && r < 6) begin
      if ($urandom_range(0, 1) != 0) aim_at_bee();
      else begin
        HiveX = 10'($urandom_range(0, 639));
        HiveY = 10'($urandom_range(150, 460));
        BeeX  = 10'($urandom_range(0, 605));
      end
      fire_en = 1'b0;
      repeat ($urandom_range(0, 40)) tick();
      fire_en = 1'b1;
      run_until(1, 150, "rand_fire");
      run_until(2, 300, "rand_done");
      r++;
    end

    // Aimed shots until the bee is out of lives
    r = 0;
    while (m_lives > 0 && r < 4) begin
      aim_at_bee();
      run_until(1, 150, "final_fire");
      run_until(2, 300, "final_done");
      r++;
    end
    chk("final_lives", Lives, 0);
    chk("final_gameover", GameOver, 1);

    // Game over: delay expires but nothing fires
    fire_en = 1'b1;
    repeat (120) tick();
    chk("gameover_no_fire", HBulletstate, 2);
    chk("gameover_lives", Lives, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hbullet_sprite.md
HBULLET_SPRITE -- requirements
Module: hbullet_sprite

Interface
REQ-001 Parameters (name, default, meaning): HBHeight, 7, bullet height in pixels; HBSpeed, 2, pixels moved down per frame; BeeY, 429, bee sprite top row; BeeWidth, 34, bee sprite width; BeeHeight, 27, bee sprite height; HitFrames, 16, frames held in HIT; MinDelay, 30, minimum frames between shots; BottomY, 470, row at which the bullet is retired.
REQ-002 Ports (name, direction, width, meaning):
  clk_pix  in  1  25.2MHz pixel clock, sole clock
  rst_n  in  1  asynchronous active-low reset
  sx  in  10  current x position
  sy  in  10  current y position
  de  in  1  1 = visible pixel, 0 = blanking
  fire_en  in  1  1 = a live hive may fire
  HiveX  in  10  firing hive left x
  HiveY  in  10  firing hive bottom row
  BeeX  in  10  bee sprite left x
  HBulletSpriteOn  out  1  1 = bullet pixel at (sx,sy)
  HBaddress  out  3  row index into the external 1x7 bullet ROM
  xHBullet  out  10  bullet x
  yHBullet  out  10  bullet top y
  HBulletstate  out  2  0 idle, 1 moving, 2 waiting, 3 hit
  HBhitBee  out  1  one-clock pulse on bullet/bee collision
  Lives  out  2  remaining bee lives
  GameOver  out  1  1 = Lives reached 0
REQ-003 Single clock domain; rst_n is asynchronous assert, applied to every register.

Function
REQ-004 Frame tick is the single cycle with sx==639 and sy==479; all movement, state changes, LFSR advance and counters update only on frame tick.
REQ-005 Drawing: on every cycle, HBulletSpriteOn<=1 and HBaddress<=sy-yHBullet (low 3 bits) when de==1, state==1, sx==xHBullet and yHBullet<=sy<=yHBullet+HBHeight-1; otherwise HBulletSpriteOn<=0 and HBaddress holds; latency one clock.
REQ-006 State 0 (idle): on first frame tick go to 2, load delay counter with MinDelay+lfsr[5:0].
REQ-007 State 2 (waiting): decrement delay counter each frame tick; when counter==0, fire_en==1 and GameOver==0, fire: xHBullet<=min(HiveX+16,639), yHBullet<=HiveY, state<=1; if fire_en==0 or GameOver==1 at expiry, stay in 2 with counter at 0.
REQ-008 State 1 (moving): each frame tick yHBullet<=yHBullet+HBSpeed.
REQ-009 Collision (evaluated in state 1 at frame tick, on current coordinates): BeeX<=xHBullet<=BeeX+BeeWidth-1 and yHBullet+HBHeight-1>=BeeY and yHBullet<=BeeY+BeeHeight-1; on hit: HBhitBee=1 for that one clock, Lives decrements (saturating at 0), state<=3, hit counter<=HitFrames, xHBullet<=0.
REQ-010 Bottom: in state 1, yHBullet>=BottomY -> state<=2, xHBullet<=0, delay counter reloaded per REQ-006.
REQ-011 Collision and bottom in the same tick: collision wins.
REQ-012 State 3 (hit): decrement hit counter each frame tick; at 0, state<=2 with delay reload; bullet not drawn.
REQ-013 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every frame tick, never all-zero.
REQ-014 GameOver=1 combinationally whenever Lives==0; it inhibits further firing only.
REQ-015 Arithmetic is 10-bit unsigned; the HiveX+16 comparison uses 11 bits before clamping.

Reset
REQ-016 On rst_n low: HBulletstate=0, xHBullet=0, yHBullet=0, HBulletSpriteOn=0, HBaddress=0, HBhitBee=0, Lives=3, LFSR=8'hA5, counters=0; reset mid-flight discards the bullet with no hit pulse.

Verification
REQ-017 Reset release, fire_en=1, HiveX=100, HiveY=200 -> state 0->2 on tick 1; fire after MinDelay+lfsr[5:0] ticks with xHBullet=116, yHBullet=200.
REQ-018 Moving bullet, BeeX=500 (no overlap) -> y rises by 2 per tick; at y>=470 state=2, xHBullet=0, HBhitBee never pulses.
REQ-019 BeeX=100, bullet x=116 reaching y=424 -> HBhitBee one-clock pulse, Lives 3->2, state=3 for 16 ticks then 2.
REQ-020 Three hits -> Lives=0, GameOver=1; fourth delay expiry leaves state 2, no fire; further collision impossible, Lives stays 0.
REQ-021 HiveX=630 -> xHBullet=639; scan line with sx=639, sy=y..y+6, de=1 -> HBulletSpriteOn=1, HBaddress=0..6 one clock late.
REQ-022 rst_n asserted while state=1 mid-screen -> all outputs at REQ-016 values immediately (asynchronously), no HBhitBee pulse.
